// File: rtl/fft_bin_trigger.sv
// fft_bin_trigger: windowed peak detector over streamed FFT frames
// with consecutive-hit qualification, holdoff and trigger output.
module fft_bin_trigger #(
  parameter int DATA_W         = 32,
  parameter int N_BINS         = 64,
  parameter int ADDR_W         = 6,
  parameter int HITS_REQ       = 1,
  parameter int HOLDOFF_FRAMES = 0,
  parameter int MAG_W          = DATA_W/2+1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  input  logic              s_axis_tlast,
  output logic              s_axis_tready,
  input  logic [ADDR_W-1:0] target_bin,
  input  logic [1:0]        win_len,
  input  logic [MAG_W-1:0]  threshold,
  input  logic              trig_mode,
  input  logic              trig_clear,
  output logic              trigger,
  output logic              frame_done,
  output logic              frame_err,
  output logic [MAG_W-1:0]  peak_mag,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [7:0]        trig_count
);
  localparam int H    = DATA_W/2;
  localparam int AW2  = ADDR_W+2;
  localparam int HC_W = (HITS_REQ > 1) ? $clog2(HITS_REQ) : 1;
  localparam int HO_W = (HOLDOFF_FRAMES > 0) ?
                        $clog2(HOLDOFF_FRAMES+1) : 1;
  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N_BINS-1);

  typedef enum logic {COLLECT, EVAL} state_t;
  state_t state, state_d;

  logic [ADDR_W-1:0] bin_cnt;
  logic [ADDR_W-1:0] cfg_tgt;
  logic [1:0]        cfg_win;
  logic [MAG_W-1:0]  cfg_thr;
  logic              cfg_mode;
  logic [MAG_W-1:0]  run_mag;
  logic [ADDR_W-1:0] run_bin;
  logic [HC_W-1:0]   hit_cnt, hit_cnt_d;
  logic [HO_W-1:0]   holdoff, holdoff_d;
  logic              fire;

  logic [H-1:0]      re_u, im_u, abs_re, abs_im;
  logic [MAG_W-1:0]  mag;
  logic              accept, first, last_bin;
  logic              frame_end, frame_ok;
  logic [ADDR_W-1:0] eff_tgt;
  logic [1:0]        eff_win;
  logic [AW2-1:0]    win_lo, win_hi, bin_x;
  logic              in_win;
  logic [MAG_W-1:0]  base_mag, nxt_mag;
  logic [ADDR_W-1:0] base_bin, nxt_bin;

  // |-2^(H-1)| wraps to 2^(H-1) as an unsigned H-bit value
  assign re_u   = s_axis_tdata[DATA_W-1:H];
  assign im_u   = s_axis_tdata[H-1:0];
  assign abs_re = re_u[H-1] ? (~re_u + H'(1)) : re_u;
  assign abs_im = im_u[H-1] ? (~im_u + H'(1)) : im_u;
  assign mag    = MAG_W'(abs_re) + MAG_W'(abs_im);

  assign s_axis_tready = ~reset & (state == COLLECT);
  assign accept    = s_axis_tvalid & s_axis_tready;
  assign first     = (bin_cnt == '0);
  assign last_bin  = (bin_cnt == LAST_BIN);
  assign frame_end = accept & (last_bin | s_axis_tlast);
  assign frame_ok  = last_bin & s_axis_tlast;

  // bin 0 must see the config it is about to latch
  assign eff_tgt = first ? target_bin : cfg_tgt;
  assign eff_win = first ? win_len : cfg_win;
  assign win_lo  = AW2'(eff_tgt);
  assign win_hi  = win_lo + AW2'(eff_win);
  assign bin_x   = AW2'(bin_cnt);
  assign in_win  = (bin_x >= win_lo) && (bin_x <= win_hi);

  assign base_mag = first ? '0 : run_mag;
  assign base_bin = first ? eff_tgt : run_bin;
  assign nxt_mag  = (in_win && mag > base_mag) ? mag : base_mag;
  assign nxt_bin  = (in_win && mag > base_mag) ? bin_cnt : base_bin;

  always_comb begin
    state_d   = state;
    fire      = 1'b0;
    hit_cnt_d = hit_cnt;
    holdoff_d = holdoff;
    unique case (state)
      COLLECT: if (frame_end && frame_ok) state_d = EVAL;
      EVAL: begin
        state_d = COLLECT;
        if (holdoff != '0) begin
          holdoff_d = holdoff - HO_W'(1);
          hit_cnt_d = '0;
        end else if (run_mag < cfg_thr) begin
          hit_cnt_d = '0;
        end else if (hit_cnt == HC_W'(HITS_REQ-1)) begin
          fire      = 1'b1;
          hit_cnt_d = '0;
          holdoff_d = HO_W'(HOLDOFF_FRAMES);
        end else begin
          hit_cnt_d = hit_cnt + HC_W'(1);
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= COLLECT;
      bin_cnt    <= '0;
      cfg_tgt    <= '0;
      cfg_win    <= '0;
      cfg_thr    <= '0;
      cfg_mode   <= 1'b0;
      run_mag    <= '0;
      run_bin    <= '0;
      hit_cnt    <= '0;
      holdoff    <= '0;
      trigger    <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      peak_mag   <= '0;
      peak_bin   <= '0;
      trig_count <= '0;
    end else begin
      state      <= state_d;
      hit_cnt    <= hit_cnt_d;
      holdoff    <= holdoff_d;
      frame_done <= (state == EVAL);
      frame_err  <= frame_end & ~frame_ok;
      // a fire beats a simultaneous clear
      trigger    <= fire | (cfg_mode & trigger & ~trig_clear);
      if (fire) trig_count <= trig_count + 8'd1;
      if (state == EVAL) begin
        peak_mag <= run_mag;
        peak_bin <= run_bin;
      end
      if (accept) begin
        run_mag <= nxt_mag;
        run_bin <= nxt_bin;
        bin_cnt <= frame_end ? '0 : bin_cnt + ADDR_W'(1);
        if (first) begin
          cfg_tgt  <= target_bin;
          cfg_win  <= win_len;
          cfg_thr  <= threshold;
          cfg_mode <= trig_mode;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_bin_trigger.sv
// Bench for fft_bin_trigger: three parameter sets share one stimulus
// stream and are checked every cycle against a frame-level model.
module tb_fft_bin_trigger;
  localparam int NB = 64;
  localparam int NI = 3;

  logic        clk;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [5:0]  target_bin;
  logic [1:0]  win_len;
  logic [16:0] threshold;
  logic        trig_mode;
  logic        trig_clear;

  logic        tready_o [NI];
  logic        trig_o   [NI];
  logic        fd_o     [NI];
  logic        fe_o     [NI];
  logic [16:0] pm_o     [NI];
  logic [5:0]  pb_o     [NI];
  logic [7:0]  tc_o     [NI];

  fft_bin_trigger #(.HITS_REQ(1), .HOLDOFF_FRAMES(0)) u_a (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(tready_o[0]),
    .target_bin(target_bin), .win_len(win_len),
    .threshold(threshold), .trig_mode(trig_mode),
    .trig_clear(trig_clear), .trigger(trig_o[0]),
    .frame_done(fd_o[0]), .frame_err(fe_o[0]),
    .peak_mag(pm_o[0]), .peak_bin(pb_o[0]), .trig_count(tc_o[0])
  );

  fft_bin_trigger #(.HITS_REQ(3), .HOLDOFF_FRAMES(0)) u_b (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(tready_o[1]),
    .target_bin(target_bin), .win_len(win_len),
    .threshold(threshold), .trig_mode(trig_mode),
    .trig_clear(trig_clear), .trigger(trig_o[1]),
    .frame_done(fd_o[1]), .frame_err(fe_o[1]),
    .peak_mag(pm_o[1]), .peak_bin(pb_o[1]), .trig_count(tc_o[1])
  );

  fft_bin_trigger #(.HITS_REQ(1), .HOLDOFF_FRAMES(2)) u_c (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(tready_o[2]),
    .target_bin(target_bin), .win_len(win_len),
    .threshold(threshold), .trig_mode(trig_mode),
    .trig_clear(trig_clear), .trigger(trig_o[2]),
    .frame_done(fd_o[2]), .frame_err(fe_o[2]),
    .peak_mag(pm_o[2]), .peak_bin(pb_o[2]), .trig_count(tc_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40)
        $display("FAIL %s[%0d]: got %0d expected %0d at %0t",
                 nm, idx, act, exp, $time);
    end
  endtask

  function automatic int hits_req(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  function automatic int hold_req(input int i);
    return (i == 2) ? 2 : 0;
  endfunction

  function automatic int mag_of(input logic [31:0] d);
    int re, im;
    re = $signed(d[31:16]);
    im = $signed(d[15:0]);
    if (re < 0) re = -re;
    if (im < 0) im = -im;
    return re + im;
  endfunction

  // frame-level reference model
  int  m_bin;
  bit  m_eval;
  int  mags [NB];
  int  c_tgt, c_win, c_thr;
  bit  c_mode;
  int  hc [NI];
  int  ho [NI];
  bit  e_trig [NI];
  int  e_cnt [NI];
  bit  e_fd, e_fe;
  int  e_pm, e_pb;

  always @(posedge clk) begin
    if (reset) begin
      m_eval = 0;
      m_bin  = 0;
      e_fd = 0; e_fe = 0; e_pm = 0; e_pb = 0;
      for (int i = 0; i < NI; i++) begin
        hc[i] = 0; ho[i] = 0; e_trig[i] = 0; e_cnt[i] = 0;
      end
    end else begin
      e_fd = 0;
      e_fe = 0;
      if (m_eval) begin
        int pk, pb;
        bit fire;
        pk = 0;
        pb = c_tgt;
        for (int b = c_tgt; b <= c_tgt + c_win && b < NB; b++)
          if (mags[b] > pk) begin pk = mags[b]; pb = b; end
        e_pm = pk;
        e_pb = pb;
        e_fd = 1;
        for (int i = 0; i < NI; i++) begin
          fire = 0;
          if (ho[i] > 0) begin
            ho[i]--; hc[i] = 0;
          end else if (pk < c_thr) begin
            hc[i] = 0;
          end else if (hc[i] + 1 == hits_req(i)) begin
            fire = 1; hc[i] = 0; ho[i] = hold_req(i);
            e_cnt[i] = (e_cnt[i] + 1) % 256;
          end else begin
            hc[i]++;
          end
          e_trig[i] = fire || (c_mode && e_trig[i] && !trig_clear);
        end
        m_eval = 0;
      end else begin
        for (int i = 0; i < NI; i++)
          e_trig[i] = c_mode && e_trig[i] && !trig_clear;
        if (s_axis_tvalid) begin
          if (m_bin == 0) begin
            c_tgt = target_bin; c_win = win_len;
            c_thr = threshold;  c_mode = trig_mode;
          end
          mags[m_bin] = mag_of(s_axis_tdata);
          if (m_bin == NB-1 || s_axis_tlast) begin
            if (m_bin == NB-1 && s_axis_tlast) m_eval = 1;
            else e_fe = 1;
            m_bin = 0;
          end else begin
            m_bin++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        chk("tready", i, tready_o[i], !reset && !m_eval);
        chk("frame_done", i, fd_o[i], e_fd);
        chk("frame_err", i, fe_o[i], e_fe);
        chk("trigger", i, trig_o[i], e_trig[i]);
        chk("peak_mag", i, pm_o[i], e_pm);
        chk("peak_bin", i, pb_o[i], e_pb);
        chk("trig_count", i, tc_o[i], e_cnt[i]);
      end
    end
  end

  logic [31:0] fr [NB];

  function automatic logic [31:0] mk(input int re, input int im);
    return {re[15:0], im[15:0]};
  endfunction

  task automatic clear_fr();
    for (int k = 0; k < NB; k++) fr[k] = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd_cfg();
    target_bin = 6'($urandom_range(0, 63));
    win_len    = 2'($urandom_range(0, 3));
    threshold  = 17'($urandom_range(0, 2500));
    trig_mode  = 1'($urandom_range(0, 1));
    trig_clear = ($urandom_range(0, 9) == 0);
  endtask

  task automatic send_beat(input logic [31:0] d, input bit last,
                           input bit rnd);
    bit hs;
    if (rnd) begin
      rnd_cfg();
      while ($urandom_range(0, 4) == 0) begin
        s_axis_tvalid = 0;
        step();
      end
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1;
    hs = 0;
    for (int w = 0; w < 8 && !hs; w++) begin
      @(negedge clk);
      hs = tready_o[0];
      step();
    end
    if (!hs) chk("beat_timeout", 0, 0, 1);
    s_axis_tvalid = 0;
    s_axis_tlast  = 0;
  endtask

  task automatic send_frame(input int n, input int last_idx,
                            input bit rnd);
    for (int k = 0; k < n; k++) send_beat(fr[k], k == last_idx, rnd);
  endtask

  initial begin
    reset = 1; s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0;
    target_bin = '0; win_len = '0; threshold = '0;
    trig_mode = 0; trig_clear = 0;
    step();
    chk_en = 1;
    chk("rst_peak", 0, pm_o[0], 0);
    chk("rst_tready", 0, tready_o[0], 0);
    step();
    reset = 0;

    // single-bin hit, then one above the peak
    target_bin = 10; win_len = 0; threshold = 1500; trig_mode = 0;
    clear_fr();
    fr[10] = mk(1000, -500);
    send_frame(NB, NB-1, 0);
    chk("t1_tready_eval", 0, tready_o[0], 0);
    step();
    chk("t1_done", 0, fd_o[0], 1);
    chk("t1_trig", 0, trig_o[0], 1);
    chk("t1_peak", 0, pm_o[0], 1500);
    chk("t1_bin", 0, pb_o[0], 10);
    chk("t1_cnt", 0, tc_o[0], 1);
    chk("t1_model_peak", 0, e_pm, 1500);
    chk("t1_trigB", 1, trig_o[1], 0);
    step();
    chk("t1_pulse_end", 0, trig_o[0], 0);
    threshold = 1501;
    send_frame(NB, NB-1, 0);
    step();
    chk("t1b_done", 0, fd_o[0], 1);
    chk("t1b_trig", 0, trig_o[0], 0);
    chk("t1b_cnt", 0, tc_o[0], 1);

    // window with a tie; a bigger bin just outside it
    target_bin = 20; win_len = 2; threshold = 65535;
    clear_fr();
    fr[20] = mk(300, 0);
    fr[21] = mk(-700, 0);
    fr[22] = mk(350, -350);
    fr[23] = mk(9000, 0);
    send_frame(NB, NB-1, 0);
    chk("t2_tready_eval", 0, tready_o[0], 0);
    step();
    chk("t2_peak", 0, pm_o[0], 700);
    chk("t2_bin", 0, pb_o[0], 21);
    chk("t2_tready_back", 0, tready_o[0], 1);
    chk("t2_model_bin", 0, e_pb, 21);

    // consecutive hits: hit hit miss hit hit hit
    target_bin = 10; win_len = 0;
    clear_fr();
    fr[10] = mk(1000, -500);
    for (int f = 0; f < 6; f++) begin
      threshold = (f == 2) ? 1501 : 1500;
      send_frame(NB, NB-1, 0);
      step();
      if (f == 4) chk("t3_trigB_f5", 1, trig_o[1], 0);
    end
    chk("t3_trigB_f6", 1, trig_o[1], 1);
    chk("t3_cntB", 1, tc_o[1], 1);

    // latched mode with holdoff on instance C
    threshold = 1500; trig_mode = 1;
    send_frame(NB, NB-1, 0);
    step();
    chk("t4_trigC_f1", 2, trig_o[2], 1);
    trig_clear = 1;
    step();
    trig_clear = 0;
    chk("t4_clear1", 2, trig_o[2], 0);
    for (int f = 0; f < 2; f++) begin
      send_frame(NB, NB-1, 0);
      step();
      chk("t4_holdoff", 2, trig_o[2], 0);
    end
    send_frame(NB, NB-1, 0);
    trig_clear = 1;
    step();
    trig_clear = 0;
    chk("t4_fire_wins", 2, trig_o[2], 1);
    chk("t4_cntC", 2, tc_o[2], 5);
    step();
    chk("t4_latched", 2, trig_o[2], 1);
    trig_clear = 1;
    step();
    trig_clear = 0;
    chk("t4_clear2", 2, trig_o[2], 0);

    // framing errors
    trig_mode = 0;
    send_frame(31, 30, 0);
    chk("t5_err_early", 0, fe_o[0], 1);
    step();
    chk("t5_no_done", 0, fd_o[0], 0);
    threshold = 1501;
    send_frame(NB, NB-1, 0);
    step();
    threshold = 1500;
    send_frame(NB, NB-1, 0);
    step();
    fr[10] = mk(100, 0);
    send_frame(NB, -1, 0);
    chk("t5_err_notlast", 0, fe_o[0], 1);
    step();
    chk("t5_peak_kept", 0, pm_o[0], 1500);
    fr[10] = mk(1000, -500);
    send_frame(NB, NB-1, 0);
    step();
    chk("t5_trigB_2", 1, trig_o[1], 0);
    send_frame(NB, NB-1, 0);
    step();
    chk("t5_trigB_3", 1, trig_o[1], 1);
    chk("t5_cntB", 1, tc_o[1], 3);

    // full-scale negative bin, then reset mid-frame
    target_bin = 5; win_len = 0; threshold = 65536;
    clear_fr();
    fr[5] = mk(-32768, -32768);
    send_frame(NB, NB-1, 0);
    step();
    chk("t6_peak", 0, pm_o[0], 65536);
    chk("t6_trig", 0, trig_o[0], 1);
    send_frame(40, -1, 0);
    reset = 1;
    step();
    step();
    chk("t6_rst_peak", 0, pm_o[0], 0);
    chk("t6_rst_cnt", 0, tc_o[0], 0);
    chk("t6_rst_tready", 0, tready_o[0], 0);
    reset = 0;
    send_frame(NB, NB-1, 0);
    step();
    chk("t6_after_done", 0, fd_o[0], 1);
    chk("t6_after_peak", 0, pm_o[0], 65536);

    // randomized frames, config churn and stalls
    for (int f = 0; f < 40; f++) begin
      int r, idx;
      for (int k = 0; k < NB; k++) begin
        if ($urandom_range(0, 29) == 0)
          fr[k] = mk(-32768, $urandom_range(0, 1) ? 32767 : -32768);
        else
          fr[k] = mk(int'($urandom_range(0, 2000)) - 1000,
                     int'($urandom_range(0, 2000)) - 1000);
      end
      r = $urandom_range(0, 9);
      if (r == 0) begin
        idx = $urandom_range(0, 62);
        send_frame(idx + 1, idx, 1);
      end else if (r == 1) begin
        send_frame(NB, -1, 1);
      end else begin
        send_frame(NB, NB-1, 1);
      end
      repeat ($urandom_range(0, 3)) step();
    end

    step();
    step();
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fft_bin_trigger.md
Name: fft_bin_trigger

Overview:
Streaming successor to the single-bin FFT trigger. Accepts one FFT frame per N_BINS beats on an AXI-Stream slave. Tracks the peak L1 magnitude inside a programmable bin window, and compares it against a threshold at frame end. Raises a trigger after HITS_REQ consecutive hit frames, then applies a frame-count holdoff. Sits between the FFT core output and the acoustics capture/control logic.

Parameters:
DATA_W, 32, beat width; upper half = signed real, lower half = signed imag
N_BINS, 64, bins per frame
ADDR_W, 6, bin index width; must satisfy 2**ADDR_W >= N_BINS
HITS_REQ, 1, consecutive hit frames required to trigger (>=1)
HOLDOFF_FRAMES, 0, evaluated frames ignored after a trigger
MAG_W, DATA_W/2+1, magnitude/threshold width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_W  FFT bin sample
s_axis_tvalid  in  1  sample valid
s_axis_tlast  in  1  last bin of frame
s_axis_tready  out  1  sample accepted when tvalid&tready
target_bin  in  ADDR_W  first bin of window
win_len  in  2  window length-1 (0..3 -> 1..4 bins)
threshold  in  MAG_W  hit when peak >= threshold
trig_mode  in  1  0 = one-cycle pulse, 1 = latched
trig_clear  in  1  clears latched trigger
trigger  out  1  trigger output
frame_done  out  1  one-cycle pulse per evaluated frame
frame_err  out  1  one-cycle pulse per discarded frame
peak_mag  out  MAG_W  peak of last evaluated frame
peak_bin  out  ADDR_W  bin of that peak
trig_count  out  8  triggers since reset, wraps

Behaviour:
- Reset values:
  - All outputs 0 during reset; tready 0.
  - State COLLECT, bin counter 0, hit counter 0, holdoff 0.
  - A partial frame in progress at reset is discarded; the first beat after reset is bin 0.
- States:
  - COLLECT: tready=1.
  - EVAL: exactly 1 cycle, tready=0.
  - Transitions: COLLECT->EVAL on frame end; EVAL->COLLECT always.
- Config latch: target_bin, win_len, threshold and trig_mode are latched on the bin-0 handshake. Changes mid-frame take effect next frame.
- Magnitude:
  - mag = |re| + |im|, unsigned MAG_W bits.
  - |-2^(DATA_W/2-1)| = 2^(DATA_W/2-1) exactly, with no overflow.
- Window:
  - Covers bins b with target_bin <= b <= target_bin+win_len and b <= N_BINS-1. There is no wrap.
  - Peak updates only on strictly greater mag, so on ties the lowest bin wins.
  - Empty window (target_bin >= N_BINS): peak_mag=0 and peak_bin=target_bin.
- Frame end: the accepted beat with bin counter = N_BINS-1, or the accepted beat with tlast, whichever comes first.
  - If both coincide: valid frame, go to EVAL.
  - If they do not coincide (early tlast, or missing tlast at bin N_BINS-1): frame_err pulses the next cycle. The frame is discarded, with no EVAL, no frame_done, and no change to hit/holdoff/peak outputs. The bin counter returns to 0.
- Timing: with the last beat accepted at cycle t:
  - EVAL occurs at t+1.
  - At t+2, peak_mag/peak_bin are updated, frame_done pulses, the trigger decision is visible, and tready=1 again.
- Decision (EVAL), hit = peak >= threshold:
  - holdoff>0: decrement holdoff; hit counter forced to 0; no trigger.
  - else miss: hit counter <- 0.
  - else hit with hit counter = HITS_REQ-1: fire. Hit counter <- 0, holdoff <- HOLDOFF_FRAMES, trig_count += 1.
  - else hit: hit counter += 1.
- Trigger output:
  - Pulse mode: trigger high for the single cycle t+2.
  - Latched mode: trigger stays high until trig_clear. A fire in the same cycle as trig_clear wins, so trigger stays high.
  - trig_clear has no effect in pulse mode.
- tvalid low mid-frame: stall with no timeout; the counter holds.

Test Plan:
1. HITS_REQ=1, target_bin=10, win_len=0, threshold=1500; bin10 re=1000 im=-500, other bins 0 -> at t+2 frame_done=1, trigger pulse 1 cycle, peak_mag=1500, peak_bin=10, trig_count=1. Repeat with threshold=1501 -> frame_done only.
2. target_bin=20, win_len=2; bins 20/21/22 mag 300/700/700, bin 23 mag 9000 -> peak_mag=700, peak_bin=21. tready=0 exactly one cycle after the last beat.
3. HITS_REQ=3; frames hit, hit, miss, hit, hit, hit -> trigger only after frame 6, trig_count=1.
4. HOLDOFF_FRAMES=2, latched mode; four hit frames -> trigger fires on frames 1 and 4, frames 2-3 ignored. trig_clear asserted the cycle of the frame-4 fire -> trigger remains 1. trig_clear alone later -> trigger 0.
5. tlast on bin 30 -> frame_err pulse, no frame_done, next beat treated as bin 0. Frame with no tlast at bin 63 -> frame_err, discard, hit counter unchanged.
6. Bin re=-32768 im=-32768, threshold=65536 -> peak_mag=65536, hit. Reset asserted mid-frame at bin 40 -> outputs 0. The next 64-beat frame with tlast evaluates normally.
